// File: rtl/rvvi_retire_collector_if.sv
// Retirement and late-writeback port bundle between the core and the
// RVVI retire collector.
interface rvvi_retire_collector_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = $clog2(DEPTH)
);
  logic             ret_valid_i;
  logic             ret_ready_o;
  logic [31:0]      ret_pc_i;
  logic [31:0]      ret_insn_i;
  logic             ret_trap_i;
  logic             ret_rd_we_i;
  logic             ret_rd_fp_i;
  logic [4:0]       ret_rd_addr_i;
  logic [31:0]      ret_rd_wdata_i;
  logic             ret_wb_pending_i;
  logic             ret_csr_we_i;
  logic [11:0]      ret_csr_addr_i;
  logic [31:0]      ret_csr_wdata_i;
  logic [TAG_W-1:0] ret_tag_o;
  logic             lwb_valid_i;
  logic [TAG_W-1:0] lwb_tag_i;
  logic [31:0]      lwb_wdata_i;

  modport master (
    output ret_valid_i, ret_pc_i, ret_insn_i,
    output ret_trap_i, ret_rd_we_i, ret_rd_fp_i,
    output ret_rd_addr_i, ret_rd_wdata_i,
    output ret_wb_pending_i, ret_csr_we_i,
    output ret_csr_addr_i, ret_csr_wdata_i,
    output lwb_valid_i, lwb_tag_i, lwb_wdata_i,
    input  ret_ready_o, ret_tag_o
  );

  modport slave (
    input  ret_valid_i, ret_pc_i, ret_insn_i,
    input  ret_trap_i, ret_rd_we_i, ret_rd_fp_i,
    input  ret_rd_addr_i, ret_rd_wdata_i,
    input  ret_wb_pending_i, ret_csr_we_i,
    input  ret_csr_addr_i, ret_csr_wdata_i,
    input  lwb_valid_i, lwb_tag_i, lwb_wdata_i,
    output ret_ready_o, ret_tag_o
  );
endinterface

// File: rtl/rvvi_retire_collector.sv
// Collects retirements plus late writebacks and emits one in-order,
// fully populated RVVI record per retired instruction.
module rvvi_retire_collector #(
  parameter int DEPTH = 4,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  rvvi_retire_collector_if.slave rif,
  output logic        rvvi_valid_o,
  output logic [63:0] rvvi_order_o,
  output logic [31:0] rvvi_pc_o,
  output logic [31:0] rvvi_insn_o,
  output logic        rvvi_trap_o,
  output logic [31:0] rvvi_x_wb_o,
  output logic [31:0] rvvi_f_wb_o,
  output logic [31:0] rvvi_rd_wdata_o,
  output logic        rvvi_csr_wb_o,
  output logic [11:0] rvvi_csr_addr_o,
  output logic [31:0] rvvi_csr_wdata_o,
  output logic        err_o
);

  localparam int CNT_W = TAG_W + 1;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic        we;
    logic        fp;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
  } slot_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic [31:0] x_wb;
    logic [31:0] f_wb;
    logic [31:0] rd_wdata;
    logic        csr_wb;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
  } rec_t;

  slot_t            slot_q [DEPTH];
  slot_t            slot_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      order_q, order_d;
  logic             err_q, err_d;
  rec_t             rec_q, rec_d;

  logic  ready;
  logic  acc;
  logic  emit;
  logic  lwb_ok;
  slot_t hs;
  slot_t ns;

  always_comb begin
    ready  = (count_q != CNT_W'(DEPTH));
    acc    = rif.ret_valid_i && ready;
    emit   = slot_q[head_q].valid && slot_q[head_q].done;
    // The slot being allocated this cycle is not yet a legal target.
    lwb_ok = slot_q[rif.lwb_tag_i].valid
          && !slot_q[rif.lwb_tag_i].done
          && !(acc && (rif.lwb_tag_i == tail_q));
  end

  assign rif.ret_ready_o = ready;
  assign rif.ret_tag_o   = tail_q;

  always_comb begin
    ns           = '0;
    ns.valid     = 1'b1;
    ns.done      = !(rif.ret_rd_we_i
                  && rif.ret_wb_pending_i
                  && !rif.ret_trap_i);
    ns.pc        = rif.ret_pc_i;
    ns.insn      = rif.ret_insn_i;
    ns.trap      = rif.ret_trap_i;
    ns.we        = rif.ret_rd_we_i
                && !rif.ret_trap_i
                && !((rif.ret_rd_addr_i == 5'd0)
                     && !rif.ret_rd_fp_i);
    ns.fp        = rif.ret_rd_fp_i;
    ns.addr      = rif.ret_rd_addr_i;
    ns.wdata     = rif.ret_rd_wdata_i;
    ns.csr_we    = rif.ret_csr_we_i;
    ns.csr_addr  = rif.ret_csr_addr_i;
    ns.csr_wdata = rif.ret_csr_wdata_i;
  end

  always_comb begin
    slot_d    = slot_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    order_d   = order_q;
    rec_d     = rec_q;
    rec_d.valid = 1'b0;
    hs        = slot_q[head_q];

    if (emit) begin
      slot_d[head_q].valid = 1'b0;
      slot_d[head_q].done  = 1'b0;
      head_d          = head_q + TAG_W'(1);
      order_d         = order_q + 64'd1;
      rec_d.valid     = 1'b1;
      rec_d.order     = order_q + 64'd1;
      rec_d.pc        = hs.pc;
      rec_d.insn      = hs.insn;
      rec_d.trap      = hs.trap;
      rec_d.x_wb      = (hs.we && !hs.fp)
                      ? (32'h1 << hs.addr) : '0;
      rec_d.f_wb      = (hs.we && hs.fp)
                      ? (32'h1 << hs.addr) : '0;
      rec_d.rd_wdata  = hs.wdata;
      rec_d.csr_wb    = hs.csr_we;
      rec_d.csr_addr  = hs.csr_addr;
      rec_d.csr_wdata = hs.csr_wdata;
    end

    if (rif.lwb_valid_i && lwb_ok) begin
      slot_d[rif.lwb_tag_i].wdata = rif.lwb_wdata_i;
      slot_d[rif.lwb_tag_i].done  = 1'b1;
    end

    if (acc) begin
      slot_d[tail_q] = ns;
      tail_d         = tail_q + TAG_W'(1);
    end

    case ({acc, emit})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    err_d = err_q
         | (rif.ret_valid_i && !ready)
         | (rif.lwb_valid_i && !lwb_ok);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      order_q <= '0;
      err_q   <= 1'b0;
      rec_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      order_q <= order_d;
      err_q   <= err_d;
      rec_q   <= rec_d;
    end
  end

  assign rvvi_valid_o     = rec_q.valid;
  assign rvvi_order_o     = rec_q.order;
  assign rvvi_pc_o        = rec_q.pc;
  assign rvvi_insn_o      = rec_q.insn;
  assign rvvi_trap_o      = rec_q.trap;
  assign rvvi_x_wb_o      = rec_q.x_wb;
  assign rvvi_f_wb_o      = rec_q.f_wb;
  assign rvvi_rd_wdata_o  = rec_q.rd_wdata;
  assign rvvi_csr_wb_o    = rec_q.csr_wb;
  assign rvvi_csr_addr_o  = rec_q.csr_addr;
  assign rvvi_csr_wdata_o = rec_q.csr_wdata;
  assign err_o            = err_q;

endmodule

// File: tb/tb_rvvi_retire_collector.sv
// Directed, table-driven bench for rvvi_retire_collector (DEPTH = 4).
module tb_rvvi_retire_collector;

  logic        clk;
  logic        rst_n;
  logic        rvvi_valid;
  logic [63:0] rvvi_order;
  logic [31:0] rvvi_pc, rvvi_insn;
  logic        rvvi_trap;
  logic [31:0] rvvi_x_wb, rvvi_f_wb, rvvi_rd_wdata;
  logic        rvvi_csr_wb;
  logic [11:0] rvvi_csr_addr;
  logic [31:0] rvvi_csr_wdata;
  logic        err;

  rvvi_retire_collector_if #(.DEPTH(4)) rif ();

  rvvi_retire_collector #(.DEPTH(4)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .rif              (rif),
    .rvvi_valid_o     (rvvi_valid),
    .rvvi_order_o     (rvvi_order),
    .rvvi_pc_o        (rvvi_pc),
    .rvvi_insn_o      (rvvi_insn),
    .rvvi_trap_o      (rvvi_trap),
    .rvvi_x_wb_o      (rvvi_x_wb),
    .rvvi_f_wb_o      (rvvi_f_wb),
    .rvvi_rd_wdata_o  (rvvi_rd_wdata),
    .rvvi_csr_wb_o    (rvvi_csr_wb),
    .rvvi_csr_addr_o  (rvvi_csr_addr),
    .rvvi_csr_wdata_o (rvvi_csr_wdata),
    .err_o            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        rv;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic        we;
    logic        fp;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic        pend;
    logic        cwe;
    logic [11:0] ca;
    logic [31:0] cd;
    logic        lv;
    logic [1:0]  lt;
    logic [31:0] ld;
    logic        e_rdy;
    logic [1:0]  e_tag;
    logic        e_err;
    logic        e_v;
    logic [63:0] e_ord;
    logic [31:0] e_x;
    logic [31:0] e_f;
    logic [31:0] e_wd;
    logic        e_trap;
    logic        e_cwe;
    logic [11:0] e_ca;
    logic [31:0] e_cd;
  } vec_t;

  vec_t vq[$];
  vec_t cur;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic R(logic [31:0] pc, logic [31:0] insn, logic trap,
                   logic we, logic fp, logic [4:0] a,
                   logic [31:0] wd, logic pend);
    cur.rv = 1'b1; cur.pc = pc; cur.insn = insn; cur.trap = trap;
    cur.we = we; cur.fp = fp; cur.addr = a; cur.wd = wd;
    cur.pend = pend;
  endtask

  task automatic C(logic [11:0] ca, logic [31:0] cd);
    cur.cwe = 1'b1; cur.ca = ca; cur.cd = cd;
  endtask

  task automatic L(logic [1:0] t, logic [31:0] d);
    cur.lv = 1'b1; cur.lt = t; cur.ld = d;
  endtask

  task automatic E(logic rdy, logic [1:0] t, logic e);
    cur.e_rdy = rdy; cur.e_tag = t; cur.e_err = e;
  endtask

  task automatic O(logic [63:0] ord, logic [31:0] x, logic [31:0] f,
                   logic [31:0] wd, logic trap);
    cur.e_v = 1'b1; cur.e_ord = ord; cur.e_x = x; cur.e_f = f;
    cur.e_wd = wd; cur.e_trap = trap;
  endtask

  task automatic OC(logic [11:0] ca, logic [31:0] cd);
    cur.e_cwe = 1'b1; cur.e_ca = ca; cur.e_cd = cd;
  endtask

  task automatic P();
    vq.push_back(cur);
    cur = '0;
  endtask

  task automatic drive(vec_t v);
    rif.ret_valid_i      = v.rv;
    rif.ret_pc_i         = v.pc;
    rif.ret_insn_i       = v.insn;
    rif.ret_trap_i       = v.trap;
    rif.ret_rd_we_i      = v.we;
    rif.ret_rd_fp_i      = v.fp;
    rif.ret_rd_addr_i    = v.addr;
    rif.ret_rd_wdata_i   = v.wd;
    rif.ret_wb_pending_i = v.pend;
    rif.ret_csr_we_i     = v.cwe;
    rif.ret_csr_addr_i   = v.ca;
    rif.ret_csr_wdata_i  = v.cd;
    rif.lwb_valid_i      = v.lv;
    rif.lwb_tag_i        = v.lt;
    rif.lwb_wdata_i      = v.ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cur = '0;
    rst_n = 1'b0;
    drive(cur);
    #12;
    chk("reset.valid", rvvi_valid, 0);
    chk("reset.order", rvvi_order, 0);
    chk("reset.x_wb", rvvi_x_wb, 0);
    chk("reset.err", err, 0);
    chk("reset.ready", rif.ret_ready_o, 1);
    chk("reset.tag", rif.ret_tag_o, 0);
    rst_n = 1'b1;
    step();

    // single retire: addi x5
    R(32'h80000000, 32'h00A00293, 0, 1, 0, 5, 32'hA, 0);
    E(1, 1, 0); P();
    E(1, 1, 0); O(1, 32'h20, 0, 32'hA, 0); P();
    E(1, 1, 0); P();
    // pending load x10 then done ALU x11
    R(32'h80000004, 32'h00052503, 0, 1, 0, 10, 0, 1);
    E(1, 2, 0); P();
    R(32'h80000008, 32'h00500593, 0, 1, 0, 11, 32'h5, 0);
    E(1, 3, 0); P();
    E(1, 3, 0); P();
    E(1, 3, 0); P();
    L(1, 32'hDEADBEEF); E(1, 3, 0); P();
    E(1, 3, 0); O(2, 32'h400, 0, 32'hDEADBEEF, 0); P();
    E(1, 3, 0); O(3, 32'h800, 0, 32'h5, 0); P();
    E(1, 3, 0); P();
    // fill all four slots with pending loads x1..x4
    for (int k = 1; k <= 4; k++) begin
      R(32'h80000010 + 32'(4 * k), 32'h00002083, 0, 1, 0,
        5'(k), 0, 1);
      E(k < 4, 2'(k - 1), 0); P();
    end
    R(32'h80000020, 32'h00100293, 0, 1, 0, 5, 32'h55, 0);
    E(0, 3, 1); P();
    L(3, 32'h111); E(0, 3, 1); P();
    E(1, 3, 1); O(4, 32'h2, 0, 32'h111, 0); P();
    L(0, 32'h222); E(1, 3, 1); P();
    L(1, 32'h333); E(1, 3, 1); O(5, 32'h4, 0, 32'h222, 0); P();
    L(2, 32'h444); E(1, 3, 1); O(6, 32'h8, 0, 32'h333, 0); P();
    E(1, 3, 1); O(7, 32'h10, 0, 32'h444, 0); P();
    // after reset: trapped ecall, then addi x0
    cur.rst = 1'b1;
    R(32'h80000100, 32'h00000073, 1, 1, 0, 5, 0, 1);
    E(1, 1, 0); P();
    R(32'h80000104, 32'h00700013, 0, 1, 0, 0, 32'h7, 0);
    E(1, 2, 0); O(1, 0, 0, 0, 1); P();
    E(1, 2, 0); O(2, 0, 0, 32'h7, 0); P();
    // fadd f3, then csrrw x6, mstatus
    R(32'h80000108, 32'h003100D3, 0, 1, 1, 3, 32'h40400000, 0);
    E(1, 3, 0); P();
    R(32'h8000010C, 32'h30029373, 0, 1, 0, 6, 32'h1, 0);
    C(12'h300, 32'h1800);
    E(1, 0, 0); O(3, 0, 32'h8, 32'h40400000, 0); P();
    E(1, 0, 0); O(4, 32'h40, 0, 32'h1, 0);
    OC(12'h300, 32'h1800); P();
    L(1, 32'hBAD); E(1, 0, 1); P();

    foreach (vq[i]) begin
      if (vq[i].rst) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      drive(vq[i]);
      step();
      chk($sformatf("row%0d.valid", i), rvvi_valid, vq[i].e_v);
      chk($sformatf("row%0d.ready", i), rif.ret_ready_o, vq[i].e_rdy);
      chk($sformatf("row%0d.tag", i), rif.ret_tag_o, vq[i].e_tag);
      chk($sformatf("row%0d.err", i), err, vq[i].e_err);
      if (vq[i].e_v) begin
        chk($sformatf("row%0d.order", i), rvvi_order, vq[i].e_ord);
        chk($sformatf("row%0d.x_wb", i), rvvi_x_wb, vq[i].e_x);
        chk($sformatf("row%0d.f_wb", i), rvvi_f_wb, vq[i].e_f);
        chk($sformatf("row%0d.wdata", i), rvvi_rd_wdata, vq[i].e_wd);
        chk($sformatf("row%0d.trap", i), rvvi_trap, vq[i].e_trap);
        chk($sformatf("row%0d.csr_wb", i), rvvi_csr_wb, vq[i].e_cwe);
        chk($sformatf("row%0d.csr_addr", i), rvvi_csr_addr, vq[i].e_ca);
        chk($sformatf("row%0d.csr_wdata", i), rvvi_csr_wdata, vq[i].e_cd);
      end
    end

    // reset with three pending slots outstanding
    for (int k = 0; k < 3; k++) begin
      cur = '0;
      R(32'h80000200, 32'h00002083, 0, 1, 0, 5'(k + 1), 0, 1);
      drive(cur);
      step();
    end
    cur = '0;
    drive(cur);
    chk("midrst.pre_tag", rif.ret_tag_o, 3);
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", rvvi_valid, 0);
    chk("midrst.order", rvvi_order, 0);
    chk("midrst.pc", rvvi_pc, 0);
    chk("midrst.x_wb", rvvi_x_wb, 0);
    chk("midrst.wdata", rvvi_rd_wdata, 0);
    chk("midrst.csr_wb", rvvi_csr_wb, 0);
    chk("midrst.csr_addr", rvvi_csr_addr, 0);
    chk("midrst.err", err, 0);
    chk("midrst.ready", rif.ret_ready_o, 1);
    chk("midrst.tag", rif.ret_tag_o, 0);
    #1;
    rst_n = 1'b1;
    R(32'h80000300, 32'h07700393, 0, 1, 0, 7, 32'h77, 0);
    drive(cur);
    step();
    cur = '0;
    drive(cur);
    chk("postrst.lat", rvvi_valid, 0);
    step();
    chk("postrst.valid", rvvi_valid, 1);
    chk("postrst.order", rvvi_order, 1);
    chk("postrst.x_wb", rvvi_x_wb, 32'h80);
    chk("postrst.pc", rvvi_pc, 32'h80000300);
    L(1, 32'h5A5A);
    drive(cur);
    step();
    cur = '0;
    drive(cur);
    chk("postrst.stale_lwb_err", err, 1);
    chk("postrst.no_stale_emit", rvvi_valid, 0);
    step();
    chk("postrst.idle", rvvi_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rvvi_retire_collector.md
Name: rvvi_retire_collector

Overview:
- Producer side of the RVVI trace path. Collects retirement events from the core's writeback stage and merges in any late register writebacks from long-latency units (loads, div, FP).
- Emits one in-order, fully populated RVVI record per retired instruction.
- Sits between the core and the rvviTrace interface. A thin wrapper assigns its flat outputs into rvvi.valid/pc_rdata/insn/trap/x_wb/x_wdata/f_wb/f_wdata/csr_wb/csr/order[0][0].

Parameters:
- DEPTH, 4, number of in-flight retirement slots (power of 2, >=2).
- TAG_W, $clog2(DEPTH), width of slot tag.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- ret_valid_i  in  1  retirement event
- ret_ready_o  out  1  slot available (= !full)
- ret_pc_i  in  32  retired PC
- ret_insn_i  in  32  instruction word
- ret_trap_i  in  1  instruction trapped
- ret_rd_we_i  in  1  instruction writes a register
- ret_rd_fp_i  in  1  destination is f-register (else x)
- ret_rd_addr_i  in  5  destination index
- ret_rd_wdata_i  in  32  write data when not pending
- ret_wb_pending_i  in  1  data arrives later on the lwb port
- ret_csr_we_i  in  1  CSR written
- ret_csr_addr_i  in  12  CSR address
- ret_csr_wdata_i  in  32  CSR value
- ret_tag_o  out  TAG_W  slot index allocated to the current retirement (tail pointer)
- lwb_valid_i  in  1  late writeback
- lwb_tag_i  in  TAG_W  slot to complete
- lwb_wdata_i  in  32  late data
- rvvi_valid_o  out  1  record valid (one cycle per record)
- rvvi_order_o  out  64  retirement count of this record
- rvvi_pc_o, rvvi_insn_o  out  32 each  record fields
- rvvi_trap_o  out  1  record field
- rvvi_x_wb_o, rvvi_f_wb_o  out  32 each  one-hot register write mask
- rvvi_rd_wdata_o  out  32  write data for the set mask bit
- rvvi_csr_wb_o  out  1  CSR written
- rvvi_csr_addr_o  out  12  CSR address
- rvvi_csr_wdata_o  out  32  CSR value
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (async): all slots invalid; head = tail = 0; count = 0; order = 0; err_o = 0; every rvvi_* output = 0.
- Slot fields: valid, done, pc, insn, trap, we, fp, addr, wdata, csr_we, csr_addr, csr_wdata.
- Accept: ret_valid_i && ret_ready_o. The slot at tail is written, tail increments mod DEPTH.
  - done = !(ret_rd_we_i && ret_wb_pending_i && !ret_trap_i).
  - we is forced to 0 when ret_trap_i = 1, or when ret_rd_addr_i = 0 && !ret_rd_fp_i (x0).
- ret_ready_o = (count != DEPTH). There is no same-cycle bypass when full.
- ret_valid_i while !ret_ready_o: ignored, err_o set.
- Late writeback: lwb_valid_i to a slot that is valid && !done → wdata = lwb_wdata_i, done = 1 at the clock edge.
  - lwb to an invalid or already-done slot: ignored, err_o set.
  - lwb to the slot being allocated in the same cycle: treated as invalid target, err_o set.
- Emit: when slot[head] is valid && done at a clock edge:
  - Output registers load that slot and rvvi_valid_o = 1 for the following cycle.
  - head increments and the slot is freed.
  - rvvi_order_o = order + 1, then order increments.
  - At most one emit per cycle. Otherwise rvvi_valid_o = 0 and the other outputs hold their last values.
- Latency: a retirement accepted at edge N with done = 1 at an empty head appears with rvvi_valid_o high in the cycle after edge N+1. A late writeback to the head at edge M gives a record in the cycle after edge M+1.
- Simultaneous accept and emit in one cycle: count is unchanged.
- Output decode on emit:
  - rvvi_x_wb_o = we && !fp ? (1 << addr) : 0; rvvi_f_wb_o likewise for fp.
  - rvvi_csr_* are copied from the slot.
- Strict in-order emission: a pending head blocks younger done slots.
- Pointers and tags wrap mod DEPTH.
- Reset mid-operation: all pending slots are discarded without emission, and order restarts at 0.

Test Plan:
1. Single retire: addi x5, pc 0x80000000, insn 0x00A00293, wdata 0xA, not pending → one rvvi_valid_o pulse 2 edges later with x_wb = 0x20, rd_wdata = 0xA, order = 1, f_wb = 0, csr_wb = 0.
2. Out-of-order late writebacks: load to x10 (tag 0, pending), then ALU to x11 (tag 1, done); lwb tag 0 data 0xDEADBEEF three cycles later → no record until that lwb; then two consecutive pulses, x10 = 0xDEADBEEF first, then x11, order 1 then 2.
3. Full: DEPTH=4, four pending retirements → ret_ready_o = 0; a fifth ret_valid_i → err_o = 1, no slot written; completing tag 0 releases one record and ret_ready_o returns to 1.
4. Trap and x0: ecall with ret_trap_i = 1 and rd_we = 1 pending → emitted without waiting, trap = 1, x_wb = 0. addi x0 → x_wb = 0.
5. FP and CSR: fadd f3 done plus csrrw mstatus 0x300 = 0x1800 → f_wb = 0x8, csr_wb = 1, csr_addr = 0x300, csr_wdata = 0x1800. Stray lwb to a free slot → err_o = 1.
6. Reset asserted with 3 pending slots → all outputs 0 immediately; after release, the first new retire reports order = 1.
